// File: rtl/fizzbuzz_pkg.sv
// Shared constants and encodings for the FizzBuzz character sequencer.
// ASCII codes, line-kind and state encodings, and a BCD conversion helper.
package fizzbuzz_pkg;

  localparam logic [6:0] ASCII_CR = 7'h0D;
  localparam logic [6:0] ASCII_LF = 7'h0A;
  localparam logic [6:0] ASCII_0  = 7'h30;
  localparam logic [6:0] ASCII_F  = 7'h46;
  localparam logic [6:0] ASCII_I  = 7'h69;
  localparam logic [6:0] ASCII_Z  = 7'h7A;
  localparam logic [6:0] ASCII_B  = 7'h42;
  localparam logic [6:0] ASCII_U  = 7'h75;

  // Character index width: the longest line is "FizzBuzz" CR LF (10 chars).
  localparam int IDX_W = 4;

  // Widest BCD value the conversion helper produces.
  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    KIND_NUM,
    KIND_FIZZ,
    KIND_BUZZ,
    KIND_FIZZBUZZ
  } line_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT,
    ST_WAIT_ACK,
    ST_WAIT_FREE,
    ST_NEXT,
    ST_HALT
  } state_t;

  // Binary to packed BCD, least significant digit in bits [3:0].
  function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value);
    logic [4*MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int d = 0; d < MAX_DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/fizzbuzz_line_rom.sv
// Combinational line generator: maps (line kind, BCD value, char index) to
// the ASCII character at that index. Numbers print MSB first with leading
// zeros skipped; every line ends in CR LF, and last flags the LF.
module fizzbuzz_line_rom
  import fizzbuzz_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  line_kind_t          kind,
  input  logic [4*DIGITS-1:0] bcd,
  input  logic [IDX_W-1:0]    idx,
  output logic [6:0]          char,
  output logic                last
);

  int         lead;
  int         len;
  int         pos;
  int         i_idx;
  logic       seen;
  logic [3:0] digit;

  // Letters of "Fizz" (buzz=0) or "Buzz" (buzz=1) at position j.
  function automatic logic [6:0] word_char(input logic buzz, input logic [1:0] j);
    case (j)
      2'd0:    return buzz ? ASCII_B : ASCII_F;
      2'd1:    return buzz ? ASCII_U : ASCII_I;
      default: return ASCII_Z;
    endcase
  endfunction

  // Count leading zero digits (digit 0 always prints), then pick the character.
  always_comb begin
    lead = 0;
    seen = 1'b0;
    for (int d = DIGITS - 1; d > 0; d--) begin
      if (!seen && bcd[4*d +: 4] == 4'd0) lead = lead + 1;
      else seen = 1'b1;
    end

    i_idx = int'(idx);
    case (kind)
      KIND_FIZZ, KIND_BUZZ: len = 4;
      KIND_FIZZBUZZ:        len = 8;
      default:              len = DIGITS - lead;
    endcase

    pos   = DIGITS - 1 - lead - i_idx;
    digit = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (d == pos) digit = bcd[4*d +: 4];
    end

    char = ASCII_LF;
    last = 1'b0;
    if (i_idx < len) begin
      case (kind)
        KIND_NUM:  char = ASCII_0 + {3'b000, digit};
        KIND_FIZZ: char = word_char(1'b0, idx[1:0]);
        KIND_BUZZ: char = word_char(1'b1, idx[1:0]);
        default:   char = word_char(idx[2], idx[1:0]);
      endcase
    end else if (i_idx == len) begin
      char = ASCII_CR;
    end else begin
      char = ASCII_LF;
      last = 1'b1;
    end
  end

endmodule

// File: rtl/fizzbuzz_seq.sv
// FizzBuzz text source for a serial transmitter, values 1..MAX_COUNT.
// Handshake: send is a one-cycle request that may only be raised while busy
// is low; the transmitter answers by raising busy, and the next character is
// offered only after busy has returned low. char is held from the send cycle
// until the next send.
// Optional build macro FIZZBUZZ_LOOP_EN: restart from 1 after MAX_COUNT and
// pulse done for one cycle per pass instead of halting with done held high.
module fizzbuzz_seq
  import fizzbuzz_pkg::*;
#(
  parameter int MAX_COUNT = 100,
  parameter int DIGITS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       busy,
  output logic [6:0] char,
  output logic       send,
  output logic       done
);

  localparam int              BCD_W   = 4 * DIGITS;
  localparam logic [BCD_W-1:0] MAX_BCD = BCD_W'(to_bcd(MAX_COUNT));
  localparam logic [BCD_W-1:0] ONE_BCD = BCD_W'(1);

  state_t             state;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_inc;
  logic               carry;
  logic [1:0]         mod3;
  logic [2:0]         mod5;
  logic [IDX_W-1:0]   idx;
  logic               last_sent;
  line_kind_t         kind;
  logic [6:0]         rom_char;
  logic               rom_last;

  // Line kind from the divisibility counters.
  always_comb begin
    kind = KIND_NUM;
    if (mod3 == 2'd0 && mod5 == 3'd0) kind = KIND_FIZZBUZZ;
    else if (mod3 == 2'd0)            kind = KIND_FIZZ;
    else if (mod5 == 3'd0)            kind = KIND_BUZZ;
  end

  // BCD increment with ripple carry from the least significant digit.
  always_comb begin
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (bcd[4*d +: 4] == 4'd9) begin
          bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          bcd_inc[4*d +: 4] = bcd[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  fizzbuzz_line_rom #(
    .DIGITS(DIGITS)
  ) u_rom (
    .kind (kind),
    .bcd  (bcd),
    .idx  (idx),
    .char (rom_char),
    .last (rom_last)
  );

  // Sequencer: transmitter handshake plus value, line and character stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      send      <= 1'b0;
      char      <= '0;
      done      <= 1'b0;
      bcd       <= ONE_BCD;
      mod3      <= 2'd1;
      mod5      <= 3'd1;
      idx       <= '0;
      last_sent <= 1'b0;
    end else begin
`ifdef FIZZBUZZ_LOOP_EN
      done <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (!busy) begin
            send      <= 1'b1;
            char      <= rom_char;
            last_sent <= rom_last;
            state     <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          send <= 1'b0;
          if (busy) state <= ST_WAIT_FREE;
        end
        ST_WAIT_FREE: begin
          if (!busy) begin
            if (last_sent) begin
              state <= ST_NEXT;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_EMIT;
            end
          end
        end
        ST_NEXT: begin
          idx <= '0;
          if (bcd == MAX_BCD) begin
`ifdef FIZZBUZZ_LOOP_EN
            bcd   <= ONE_BCD;
            mod3  <= 2'd1;
            mod5  <= 3'd1;
            done  <= 1'b1;
            state <= ST_EMIT;
`else
            done  <= 1'b1;
            state <= ST_HALT;
`endif
          end else begin
            bcd   <= bcd_inc;
            mod3  <= (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
            mod5  <= (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
            state <= ST_EMIT;
          end
        end
        ST_HALT: begin
          if (start) begin
            bcd   <= ONE_BCD;
            mod3  <= 2'd1;
            mod5  <= 3'd1;
            idx   <= '0;
            done  <= 1'b0;
            state <= ST_EMIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fizzbuzz_seq.sv
// Bench for fizzbuzz_seq: two instances (MAX_COUNT=15 with 2 digits and
// MAX_COUNT=101 with 3 digits), each driven by a transmitter model with a
// configurable or random busy time. Expected text is built from the FizzBuzz
// rules with plain integer arithmetic and string formatting.
module tb_fizzbuzz_seq;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start_s [2];
  logic       busy_s  [2];
  logic       send_s  [2];
  logic [6:0] char_s  [2];
  logic       done_s  [2];

  // transmitter model state
  logic       tx_busy  [2] = '{1'b0, 1'b0};
  logic       hold     [2] = '{1'b0, 1'b0};
  int         tx_cnt   [2] = '{0, 0};
  int         fixed_len[2] = '{20, 0};
  int         n_send   [2] = '{0, 0};
  logic       prev_send[2] = '{1'b0, 1'b0};
  logic [6:0] prev_char[2] = '{7'h0, 7'h0};
  int         proto_err = 0;

  logic [6:0] rx0 [$];
  logic [6:0] rx1 [$];
  logic [6:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  assign busy_s[0] = tx_busy[0] | hold[0];
  assign busy_s[1] = tx_busy[1] | hold[1];

  fizzbuzz_seq #(.MAX_COUNT(15), .DIGITS(2)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .start (start_s[0]),
    .busy  (busy_s[0]),
    .char  (char_s[0]),
    .send  (send_s[0]),
    .done  (done_s[0])
  );

  fizzbuzz_seq #(.MAX_COUNT(101), .DIGITS(3)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .start (start_s[1]),
    .busy  (busy_s[1]),
    .char  (char_s[1]),
    .send  (send_s[1]),
    .done  (done_s[1])
  );

  // ---------------- transmitter model + protocol monitor ----------------
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        tx_busy[k] = 1'b0;
        tx_cnt[k]  = 0;
      end else if (send_s[k]) begin
        n_send[k]++;
        if (prev_send[k] || busy_s[k]) proto_err++;
        if (k == 0) rx0.push_back(char_s[0]);
        else        rx1.push_back(char_s[1]);
        tx_busy[k] = 1'b1;
        tx_cnt[k]  = (fixed_len[k] != 0) ? fixed_len[k] : int'($urandom_range(1, 6));
      end else begin
        if (char_s[k] !== prev_char[k]) proto_err++;
        if (tx_busy[k]) begin
          if (tx_cnt[k] <= 1) tx_busy[k] = 1'b0;
          else tx_cnt[k]--;
        end
      end
      prev_send[k] = send_s[k];
      prev_char[k] = char_s[k];
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference text for values 1..n.
  task automatic build_exp(input int n);
    string s;
    exp_q.delete();
    for (int v = 1; v <= n; v++) begin
      if (v % 15 == 0)     s = "FizzBuzz";
      else if (v % 3 == 0) s = "Fizz";
      else if (v % 5 == 0) s = "Buzz";
      else                 s = $sformatf("%0d", v);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(7'(s[i]));
      exp_q.push_back(7'h0D);
      exp_q.push_back(7'h0A);
    end
  endtask

  function automatic int rx_size(input int k);
    return (k == 0) ? rx0.size() : rx1.size();
  endfunction

  task automatic compare_stream(input int k, input string tag, input int upto);
    logic [6:0] got [$];
    int lim;
    if (k == 0) got = rx0;
    else        got = rx1;
    lim = (upto > 0) ? upto : exp_q.size();
    if (upto == 0) check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < lim && i < got.size(); i++) begin
      check($sformatf("%s_char%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      if (got[i] !== exp_q[i]) break;
    end
  endtask

  task automatic wait_rx(input int k, input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (rx_size(k) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(rx_size(k) >= n), 32'd1);
  endtask

  task automatic wait_done(input int k, input int budget, input string tag);
    int c;
    c = 0;
    while (done_s[k] !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(done_s[k]), 32'd1);
  endtask

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         snap;
    logic [6:0] tail [5];
    tail = '{7'h31, 7'h30, 7'h31, 7'h0D, 7'h0A};

    rst        = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_send%0d", k), 32'(send_s[k]), 32'd0);
      check($sformatf("reset_char%0d", k), 32'(char_s[k]), 32'd0);
      check($sformatf("reset_done%0d", k), 32'(done_s[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // busy held high after start: no send may appear
    hold[0] = 1'b1;
    pulse_start(0);
    repeat (500) @(negedge clk);
    check("hold_no_send", 32'(n_send[0]), 32'd0);
    hold[0] = 1'b0;
    wait_rx(0, 1, 100, "first_send_timeout");
    check("first_send_high", 32'(send_s[0]), 32'd1);
    check("first_char", 32'(char_s[0]), 32'h31);
    @(negedge clk);
    check("first_send_low", 32'(send_s[0]), 32'd0);
    check("first_char_held", 32'(char_s[0]), 32'h31);

    // start during WAIT_FREE must not disturb the stream
    wait_rx(0, 5, 400, "rx5_timeout");
    repeat (2) @(negedge clk);
    pulse_start(0);

    wait_done(0, 5000, "run15_done_timeout");
    build_exp(15);
    compare_stream(0, "run15", 0);
    check("run15_count", 32'(n_send[0]), 32'd73);
    snap = n_send[0];
    repeat (200) @(negedge clk);
    check("halt_no_send", 32'(n_send[0]), 32'(snap));
    check("halt_done", 32'(done_s[0]), 32'd1);

    // start in HALT: fresh run with random busy lengths
    fixed_len[0] = 0;
    rx0.delete();
    pulse_start(0);
    check("restart_done_clr", 32'(done_s[0]), 32'd0);
    wait_rx(0, 9, 1000, "rx9_timeout");

    // reset while the third letter of "Fizz" is in flight
    rst = 1'b1;
    @(negedge clk);
    check("midreset_send", 32'(send_s[0]), 32'd0);
    check("midreset_done", 32'(done_s[0]), 32'd0);
    check("midreset_char", 32'(char_s[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rx0.delete();
    repeat ($urandom_range(0, 5)) @(negedge clk);
    pulse_start(0);
    wait_rx(0, 3, 200, "post_reset_timeout");
    compare_stream(0, "post_reset", 3);
    wait_done(0, 5000, "rerun15_done_timeout");
    compare_stream(0, "rerun15", 0);

    // wider instance across the 9->10 and 99->100 digit-count changes
    repeat ($urandom_range(0, 5)) @(negedge clk);
    pulse_start(1);
    wait_done(1, 30000, "run101_done_timeout");
    build_exp(101);
    compare_stream(1, "run101", 0);
    if (rx1.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        check($sformatf("line101_char%0d", i), 32'(rx1[rx1.size() - 5 + i]), 32'(tail[i]));
    end else begin
      check("line101_len", 32'(rx1.size()), 32'd5);
    end

    check("protocol_errors", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
